// File: rtl/jk_seq_ctrl_if.sv
// Command channel between the control logic and jk_seq_ctrl.
//   cmd_valid : command present (master -> slave)
//   cmd_ready : controller can accept a command (slave -> master)
//   cmd_op    : 0 NOP, 1 SET, 2 CLEAR, 3 TOGGLE, 4 COUNT_UP, 5 COUNT_DOWN, 6/7 reserved
//   cmd_mask  : bit select for SET/CLEAR/TOGGLE
//   cmd_len   : number of count steps for COUNT ops
interface jk_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_mask,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_mask,
    input  cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/jk_seq_ctrl.sv
// Command-driven sequencer for a bank of WIDTH JK flip-flops.
// Ports:
//   clk  : clock shared with the JK bank (rising edge)
//   rst  : synchronous active-high reset
//   cmd  : command channel (slave side of jk_seq_ctrl_if)
//   q    : Q feedback from the bank
//   j, k : J/K vectors to the bank (zero outside EXEC, bank holds)
//   busy : high in EXEC and DONE
//   done : one-cycle completion pulse (DONE state)
module jk_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_seq_ctrl_if.slave     cmd,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  localparam logic [2:0] OpSet    = 3'd1;
  localparam logic [2:0] OpClear  = 3'd2;
  localparam logic [2:0] OpToggle = 3'd3;
  localparam logic [2:0] OpUp     = 3'd4;
  localparam logic [2:0] OpDown   = 3'd5;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  logic             is_count;
  logic [WIDTH-1:0] up_t, dn_t;
  logic             up_c, dn_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      mask_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
    end
  end

  assign is_count = (op_q == OpUp) || (op_q == OpDown);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mask_d  = mask_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          op_d   = cmd.cmd_op;
          mask_d = cmd.cmd_mask;
          rem_d  = cmd.cmd_len;
          case (cmd.cmd_op)
            OpSet, OpClear, OpToggle: state_d = StExec;
            // Zero-length counts have nothing to drive, so skip EXEC.
            OpUp, OpDown: state_d = (cmd.cmd_len != '0) ? StExec : StDone;
            default: state_d = StDone;
          endcase
        end
      end
      StExec: begin
        if (is_count) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = StDone;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ripple toggle-enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_t = '0;
    dn_t = '0;
    up_c = 1'b1;
    dn_c = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      up_t[i] = up_c;
      dn_t[i] = dn_c;
      up_c    = up_c & q[i];
      dn_c    = dn_c & ~q[i];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (state_q == StExec) begin
      case (op_q)
        OpSet:    j = mask_q;
        OpClear:  k = mask_q;
        OpToggle: begin j = mask_q; k = mask_q; end
        OpUp:     begin j = up_t;   k = up_t;   end
        OpDown:   begin j = dn_t;   k = dn_t;   end
        default:  begin j = '0;     k = '0;     end
      endcase
    end
  end

  assign cmd.cmd_ready = (state_q == StIdle);
  assign busy          = (state_q == StExec) || (state_q == StDone);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_jk_seq_ctrl.sv
module tb_jk_seq_ctrl;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] j, k;
  logic             busy, done;
  logic [WIDTH-1:0] bank_q = 4'h0;

  jk_seq_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) cmd_if ();

  jk_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd_if),
    .q    (bank_q),
    .j    (j),
    .k    (k),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank, no reset.
  always @(posedge clk) begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({j[i], k[i]})
        2'b10:   bank_q[i] <= 1'b1;
        2'b01:   bank_q[i] <= 1'b0;
        2'b11:   bank_q[i] <= ~bank_q[i];
        default: bank_q[i] <= bank_q[i];
      endcase
    end
  end

  typedef struct {
    logic [WIDTH-1:0] q;
    int               lat;
    int               acc;
    int               op;
  } exp_t;

  exp_t             exp_queue[$];
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               busy_cnt = 0;
  bit               mon_en = 1'b0;
  logic [WIDTH-1:0] ref_q = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: final bank value after a command, by plain arithmetic.
  function automatic logic [WIDTH-1:0] model_q(input int op, input logic [WIDTH-1:0] mask,
                                               input int len, input logic [WIDTH-1:0] cur);
    int m = 1 << WIDTH;
    case (op)
      1:       return cur | mask;
      2:       return cur & ~mask;
      3:       return cur ^ mask;
      4:       return WIDTH'((int'(cur) + len) % m);
      5:       return WIDTH'(((int'(cur) - len) % m + m) % m);
      default: return cur;
    endcase
  endfunction

  // Cycles from accept edge to the DONE cycle (inclusive of busy span).
  function automatic int model_lat(input int op, input int len);
    if (op >= 1 && op <= 3) return 2;
    if (op == 4 || op == 5) return (len == 0) ? 1 : len + 1;
    return 1;
  endfunction

  task automatic issue(input int op, input logic [WIDTH-1:0] mask, input int len,
                       input bit track);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'(op);
    cmd_if.cmd_mask  = mask;
    cmd_if.cmd_len   = LEN_W'(len);
    while (!cmd_if.cmd_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_if.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d never accepted", op);
      cmd_if.cmd_valid = 1'b0;
      return;
    end
    if (track) begin
      e.q   = model_q(op, mask, len, ref_q);
      e.lat = model_lat(op, len);
      e.acc = cyc;
      e.op  = op;
      exp_queue.push_back(e);
      ref_q = e.q;
    end
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      if (busy) busy_cnt++;
      else busy_cnt = 0;
      check("ready_vs_busy", {31'd0, cmd_if.cmd_ready}, {31'd0, !busy});
      if (!busy || done) check("jk_quiet", {24'd0, j, k}, 32'd0);
      if (done) begin
        if (exp_queue.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done with no outstanding command (t=%0t)", $time);
        end else begin
          e = exp_queue.pop_front();
          check($sformatf("q_after_op%0d", e.op), {28'd0, bank_q}, {28'd0, e.q});
          check($sformatf("latency_op%0d", e.op), cyc - e.acc, e.lat);
          check($sformatf("busy_span_op%0d", e.op), busy_cnt, e.lat);
        end
      end
    end
  end

  initial begin
    int waited;
    // Reset with a command presented at the same time: must not be accepted.
    rst              = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'd1;
    cmd_if.cmd_mask  = 4'hF;
    cmd_if.cmd_len   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("rst_jk", {24'd0, j, k}, 32'd0);
    check("rst_no_accept_q", {28'd0, bank_q}, 32'd0);
    rst              = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    mon_en           = 1'b1;

    // Directed plan.
    issue(2, 4'hF, 0, 1);
    issue(1, 4'b1010, 0, 1);
    issue(3, 4'b0110, 0, 1);
    check("toggle_jk", {24'd0, j, k}, {24'd0, 4'b0110, 4'b0110});
    issue(1, 4'b0010, 0, 1);
    issue(4, 4'h0, 5, 1);
    issue(2, 4'hF, 0, 1);
    issue(1, 4'b0001, 0, 1);
    issue(5, 4'h0, 3, 1);
    issue(4, 4'h0, 0, 1);
    issue(7, 4'hF, 9, 1);
    issue(6, 4'h3, 2, 1);

    // Abort mid-count: reset lands in the 3rd EXEC cycle.
    issue(2, 4'hF, 0, 1);
    issue(4, 4'h0, 10, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_q", {28'd0, bank_q}, 32'h3);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check("abort_jk", {24'd0, j, k}, 32'd0);
    ref_q = 4'h3;

    // Back-to-back commands: each new one is held while the previous is busy.
    for (int n = 0; n < 40; n++) begin
      int op  = int'($urandom_range(0, 7));
      int len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 12));
      issue(op, WIDTH'($urandom), len, 1);
    end

    waited = 0;
    while ((exp_queue.size() != 0 || busy) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (exp_queue.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_queue.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
